// File: rtl/vga_fb_arbiter_pkg.sv
// vga_fb_arbiter_pkg: constants and CPU-port FSM encoding shared by the framebuffer arbiter.
// Revision: 1.0
`default_nettype none

package vga_fb_arbiter_pkg;

   localparam int PIX_PER_WORD = 8;
   localparam int PIX_IDX_W    = $clog2(PIX_PER_WORD);
   localparam int PIX_LAT_DEF  = 3;

   typedef enum logic [1:0] {
      CPU_IDLE  = 2'd0,
      CPU_ISSUE = 2'd1,
      CPU_ACK   = 2'd2
   } cpu_state_e;

endpackage

`default_nettype wire

// File: rtl/vga_pix_shifter.sv
// vga_pix_shifter: MSB-first 8-bit pixel serialiser plus the active-video delay line.
// Revision: 1.0
`default_nettype none

module vga_pix_shifter #(
   parameter int LAT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_i,
   input  logic [7:0] data_i,
   input  logic       active_i,
   output logic       pix_o,
   output logic       active_o
);

   logic [7:0]     sh_q;
   logic [7:0]     sh_d;
   logic [LAT-1:0] act_q;
   logic [LAT-1:0] act_d;

   always_comb begin
      sh_d  = load_i ? data_i : {sh_q[6:0], 1'b0};
      act_d = {act_q[LAT-2:0], active_i};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_q  <= 8'h00;
         act_q <= '0;
      end else begin
         sh_q  <= sh_d;
         act_q <= act_d;
      end
   end

   assign active_o = act_q[LAT-1];
   assign pix_o    = sh_q[7] & act_q[LAT-1];

endmodule

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a 1-cycle-latency framebuffer RAM between video scanout
// (absolute priority) and a req/ack CPU port; serialises fetched words to 1 bpp.  Revision: 1.0
`default_nettype none

module vga_fb_arbiter
   import vga_fb_arbiter_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] FB_BASE  = '0,
   parameter int                FB_WORDS = 38400,
   parameter int                PIX_LAT  = PIX_LAT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [10:0]       vga_x,
   input  logic [10:0]       vga_y,
   input  logic              vga_active,
   input  logic              vga_frame_start,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic              pix_out,
   output logic              pix_active
);

   localparam logic [ADDR_W-1:0] VID_LAST = ADDR_W'(int'(FB_BASE) + FB_WORDS - 1);

   cpu_state_e        state_q, state_d;
   logic              cpu_grant;
   logic              slot;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_we_q, ram_we_d;
   logic [7:0]        ram_wdata_q, ram_wdata_d;
   logic              op_we_q, op_we_d;
   logic              fetch1_q, fetch2_q;

   assign slot       = vga_active && (vga_x[PIX_IDX_W-1:0] == '0);
   // A frame-start pulse landing on a slot must already fetch from the base.
   assign fetch_addr = vga_frame_start ? FB_BASE : vid_addr_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= CPU_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CPU_IDLE:  if (cpu_grant) state_d = CPU_ISSUE;
         CPU_ISSUE: state_d = CPU_ACK;
         CPU_ACK:   state_d = CPU_IDLE;
         default:   state_d = CPU_IDLE;
      endcase
   end

   always_comb begin
      cpu_grant = (state_q == CPU_IDLE) && cpu_req && !slot;
      cpu_ack   = (state_q == CPU_ACK);
      cpu_rdata = ((state_q == CPU_ACK) && !op_we_q) ? ram_rdata : 8'h00;
   end

   always_comb begin
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      op_we_d     = op_we_q;
      vid_addr_d  = vid_addr_q;
      if (slot) begin
         ram_addr_d = fetch_addr;
         vid_addr_d = (fetch_addr == VID_LAST) ? FB_BASE : fetch_addr + ADDR_W'(1);
      end else begin
         if (vga_frame_start) vid_addr_d = FB_BASE;
         if (cpu_grant) begin
            ram_addr_d  = cpu_addr;
            ram_we_d    = cpu_we;
            ram_wdata_d = cpu_wdata;
            op_we_d     = cpu_we;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= 8'h00;
         op_we_q     <= 1'b0;
         vid_addr_q  <= FB_BASE;
         fetch1_q    <= 1'b0;
         fetch2_q    <= 1'b0;
      end else begin
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         op_we_q     <= op_we_d;
         vid_addr_q  <= vid_addr_d;
         fetch1_q    <= slot;
         fetch2_q    <= fetch1_q;
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;

   vga_pix_shifter #(
      .LAT(PIX_LAT)
   ) u_shifter (
      .clk      (clk),
      .reset    (reset),
      .load_i   (fetch2_q),
      .data_i   (ram_rdata),
      .active_i (vga_active),
      .pix_o    (pix_out),
      .active_o (pix_active)
   );

   logic unused_ok;
   assign unused_ok = ^{vga_x[10:PIX_IDX_W], vga_y};

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for the framebuffer arbiter on a reduced 64x4 frame.
// Revision: 1.0
`default_nettype none

module tb_vga_fb_arbiter;

   localparam logic [15:0] BASE  = 16'h0200;
   localparam int          WORDS = 32;
   localparam logic [15:0] LAST  = 16'h021F;
   localparam int          LINE_W = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] vga_x, vga_y;
   logic        vga_active, vga_frame_start;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        cpu_ack;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata, ram_rdata;
   logic        pix_out, pix_active;

   always #5 clk = ~clk;

   vga_fb_arbiter #(
      .ADDR_W(16), .FB_BASE(BASE), .FB_WORDS(WORDS), .PIX_LAT(3)
   ) dut (
      .clk(clk), .reset(reset),
      .vga_x(vga_x), .vga_y(vga_y), .vga_active(vga_active), .vga_frame_start(vga_frame_start),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .pix_out(pix_out), .pix_active(pix_active)
   );

   logic [7:0] mem [0:65535];

   always @(posedge clk) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] = ram_wdata;
   end

   int checks = 0;
   int failures = 0;

   logic [15:0] addr_q[$];
   logic [1:0]  pix_q[$];
   logic [15:0] m_vid;
   logic [7:0]  cur_word;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model the stimulus of the coming cycle, clock once, then score what came out.
   task automatic step();
      logic        slot, was_rst;
      logic [15:0] ea;
      logic [2:0]  bi;
      logic [1:0]  ep;
      slot    = vga_active && (vga_x[2:0] == 3'd0);
      was_rst = reset;
      if (!was_rst) begin
         if (slot) begin
            ea = vga_frame_start ? BASE : m_vid;
            addr_q.push_back(ea);
            cur_word = mem[ea];
            m_vid = (ea == LAST) ? BASE : ea + 16'd1;
         end else if (vga_frame_start) begin
            m_vid = BASE;
         end
         bi = 3'd7 - vga_x[2:0];
         pix_q.push_back(vga_active ? {1'b1, cur_word[bi]} : 2'b00);
      end
      @(posedge clk);
      #1;
      if (was_rst) begin
         m_vid = BASE;
         addr_q.delete();
         pix_q.delete();
      end else begin
         if (slot) begin
            ea = addr_q.pop_front();
            chk("vid_fetch", {15'd0, ram_we, ram_addr}, {16'd0, ea});
         end
         if (pix_q.size() == 3) begin
            ep = pix_q.pop_front();
            chk("pixel", {30'd0, pix_active, pix_out}, {30'd0, ep});
         end
      end
   endtask

   task automatic set_idle();
      vga_active = 1'b0; vga_x = 11'd0; vga_y = 11'd0; vga_frame_start = 1'b0;
   endtask

   int ones, one_pos;

   task automatic run_line(input int y, input bit fs0, input int cpu_x, input bit chk_base, input bit track);
      for (int x = 0; x < LINE_W; x++) begin
         vga_active = 1'b1; vga_x = 11'(x); vga_y = 11'(y);
         vga_frame_start = fs0 && (x == 0);
         if (x == cpu_x) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0077; end
         step();
         if (chk_base && x == 0) chk("fetch_base0", {16'd0, ram_addr}, {16'd0, BASE});
         if (chk_base && x == 8) chk("fetch_base1", {16'd0, ram_addr}, {16'd0, BASE + 16'd1});
         if (cpu_x >= 0) begin
            if (x == cpu_x)     chk("slot_no_ack", {31'd0, cpu_ack}, 32'd0);
            if (x == cpu_x + 1) chk("slot_defer_addr", {15'd0, ram_we, ram_addr}, 32'h0077);
            if (x == cpu_x + 2) begin
               chk("slot_defer_ack", {23'd0, cpu_ack, cpu_rdata}, {23'd0, 1'b1, 8'h77});
               cpu_req = 1'b0;
            end
         end
         if (track && x >= 10 && x <= 17 && pix_out) begin ones++; one_pos = x; end
      end
      set_idle();
      repeat (16) step();
   endtask

   task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] wd, input logic [7:0] exp);
      set_idle();
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      step();
      chk("op_issue", {15'd0, ram_we, ram_addr}, {15'd0, we, a});
      if (we) chk("op_wdata", {24'd0, ram_wdata}, {24'd0, wd});
      chk("op_early_ack", {31'd0, cpu_ack}, 32'd0);
      step();
      chk("op_ack", {22'd0, ram_we, cpu_ack, cpu_rdata}, {22'd0, 1'b0, 1'b1, exp});
      cpu_req = 1'b0;
      step();
      chk("op_ack_once", {31'd0, cpu_ack}, 32'd0);
   endtask

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_rdata;
   } cpu_vec_t;

   initial begin
      cpu_vec_t vecs [6];
      int ack_at [$];

      vecs[0] = '{1'b1, 16'h0100, 8'hA5, 8'h00};
      vecs[1] = '{1'b0, 16'h0100, 8'h00, 8'hA5};
      vecs[2] = '{1'b0, 16'h0033, 8'h00, 8'h33};
      vecs[3] = '{1'b1, 16'h1234, 8'h5A, 8'h00};
      vecs[4] = '{1'b0, 16'h1234, 8'hFF, 8'h5A};
      vecs[5] = '{1'b0, 16'h0201, 8'h00, 8'h01};

      for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
      m_vid = BASE; cur_word = 8'h00;
      set_idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      reset = 1'b1;
      repeat (2) step();
      chk("reset_outputs", {cpu_ack, cpu_rdata, ram_we, ram_wdata, pix_out, pix_active},
          {1'b0, 8'h00, 1'b0, 8'h00, 2'b00});
      chk("reset_addr", {16'd0, ram_addr}, 32'd0);
      reset = 1'b0;
      repeat (3) step();

      for (int i = 0; i < 6; i++)
         cpu_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

      // Continuously held read: a new grant is possible every third cycle.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0033;
      for (int i = 0; i < 12; i++) begin
         step();
         if (cpu_ack) begin
            ack_at.push_back(i);
            chk("b2b_rdata", {24'd0, cpu_rdata}, 32'h33);
         end
      end
      cpu_req = 1'b0;
      chk("b2b_count", ack_at.size(), 4);
      for (int i = 1; i < ack_at.size(); i++) chk("b2b_spacing", ack_at[i] - ack_at[i-1], 3);
      repeat (3) step();

      // Reset lands while the read is in ISSUE.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0044;
      step();
      chk("rst_mid_issue", {16'd0, ram_addr}, 32'h0044);
      reset = 1'b1;
      step();
      chk("rst_mid_outputs", {cpu_ack, cpu_rdata, ram_we, ram_wdata, pix_out, pix_active, ram_addr},
          {1'b0, 8'h00, 1'b0, 8'h00, 2'b00, 16'h0000});
      reset = 1'b0; cpu_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rst_no_ack", {31'd0, cpu_ack}, 32'd0);
      end
      cpu_op(1'b0, 16'h0044, 8'h00, 8'h44);

      // Frame: start pulse in blanking, then 4 lines, one with a slot-colliding CPU read.
      vga_frame_start = 1'b1;
      step();
      vga_frame_start = 1'b0;
      repeat (4) step();
      ones = 0; one_pos = -1;
      run_line(0, 1'b0, -1, 1'b1, 1'b1);
      chk("row0_word1_ones", ones, 1);
      chk("row0_word1_pos", one_pos, 17);
      run_line(1, 1'b0, -1, 1'b0, 1'b0);
      run_line(2, 1'b0, 16, 1'b0, 1'b0);
      run_line(3, 1'b0, -1, 1'b0, 1'b0);
      // No frame start: the word counter must have wrapped to the base.
      run_line(4, 1'b0, -1, 1'b1, 1'b0);
      // Frame start coincident with the first slot of a line.
      run_line(0, 1'b1, -1, 1'b1, 1'b0);
      run_line(1, 1'b0, -1, 1'b0, 1'b0);
      chk("addr_queue_drained", addr_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
